// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns active-low one at a time, debounces
// the synchronized rows and emits one key code plus a single-cycle pulse per press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keypadBuf,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CNT);
  localparam bit            DEB_ONE  = (DEBOUNCE_CNT == 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_meta_q, row_meta_d;
  logic [3:0]    rs_q, rs_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    key_buf_q, key_buf_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic          tick;
  logic          row_hit;
  logic [1:0]    low_row;
  logic [1:0]    col_next;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick     = (slot_q == SLOT_MAX);
  assign row_hit  = (rs_q != 4'hF);
  assign col_next = col_idx_q + 2'd1;

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    low_row = 2'd3;
    if (!rs_q[2]) low_row = 2'd2;
    if (!rs_q[1]) low_row = 2'd1;
    if (!rs_q[0]) low_row = 2'd0;
  end

  always_comb begin
    state_d     = state_q;
    row_meta_d  = row;
    rs_d        = row_meta_q;
    slot_d      = tick ? '0 : slot_q + SW'(1);
    deb_d       = deb_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_buf_d   = key_buf_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (!row_hit) begin
            col_idx_d = col_next;
          end else begin
            row_idx_d = low_row;
            deb_d     = CW'(1);
            if (DEB_ONE) begin
              key_buf_d   = key_code(low_row, col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_d       = '0;
              state_d     = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (!rs_q[row_idx_q]) begin
            if (deb_q + CW'(1) == DEB_MAX) begin
              key_buf_d   = key_code(row_idx_q, col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_d       = '0;
              state_d     = HELD;
            end else begin
              deb_d = deb_q + CW'(1);
            end
          end else begin
            deb_d     = '0;
            col_idx_d = col_next;
            state_d   = SCAN;
          end
        end
      end

      HELD: begin
        // Column stays frozen, so keys in other columns cannot disturb the release count.
        if (tick) begin
          if (!row_hit) begin
            if (deb_q + CW'(1) == DEB_MAX) begin
              deb_d      = '0;
              key_held_d = 1'b0;
              col_idx_d  = col_next;
              state_d    = SCAN;
            end else begin
              deb_d = deb_q + CW'(1);
            end
          end else begin
            deb_d = '0;
          end
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SCAN;
      row_meta_q  <= 4'hF;
      rs_q        <= 4'hF;
      slot_q      <= '0;
      deb_q       <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      key_buf_q   <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_meta_q  <= row_meta_d;
      rs_q        <= rs_d;
      slot_q      <= slot_d;
      deb_q       <= deb_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      key_buf_q   <= key_buf_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign keypadBuf = key_buf_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural 4x4 keypad drives the rows from the
// column drive, and a scoreboard queue matches every key_valid pulse to a press.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int BOUND        = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keypadBuf;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed = '0;
  logic [3:0]      sb[$];
  int              checks_done   = 0;
  int              checks_failed = 0;
  int              pulse_count   = 0;
  logic            prev_valid    = 1'b0;

  always #5 clock = ~clock;

  // A pressed key shorts its row to its column; rows idle high through pull-ups.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .keypadBuf(keypadBuf),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks_done++;
    if (observed !== expected) begin
      checks_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  always @(negedge clock) begin
    if (key_valid !== 1'b0) begin
      pulse_count <= pulse_count + 1;
      checkOutput("pulse_width", {7'd0, prev_valid}, 8'd0);
      if (sb.size() == 0) checkOutput("unexpected_pulse", 8'd1, 8'd0);
      else checkOutput("pulse_code", {4'd0, keypadBuf}, {4'd0, sb.pop_front()});
    end
    prev_valid <= key_valid;
  end

  task automatic cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_pulse(input int target, input string tag);
    int n = 0;
    while (pulse_count < target && n < BOUND) begin
      cycle();
      n++;
    end
    checkOutput({tag, "_pulse_seen"}, {7'd0, pulse_count >= target}, 8'd1);
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    while (key_held !== 1'b0 && n < BOUND) begin
      cycle();
      n++;
    end
    checkOutput({tag, "_released"}, {7'd0, key_held}, 8'd0);
  endtask

  task automatic wait_col(input logic [3:0] target);
    logic [3:0] prev;
    int n = 0;
    do begin
      prev = col;
      cycle();
      n++;
    end while (!(col == target && prev != target) && n < BOUND);
    checkOutput("col_reach", {4'd0, col}, {4'd0, target});
  endtask

  task automatic applyStimulus(input int r, input int c, input logic [3:0] code, input string tag);
    int start = pulse_count;
    sb.push_back(code);
    pressed[r][c] = 1'b1;
    wait_pulse(start + 1, tag);
    checkOutput({tag, "_buf"}, {4'd0, keypadBuf}, {4'd0, code});
    checkOutput({tag, "_held"}, {7'd0, key_held}, 8'd1);
    pressed[r][c] = 1'b0;
    wait_release(tag);
  endtask

  initial begin
    int start;
    logic [3:0] col_exp;

    cycle();
    cycle();
    checkOutput("rst_col", {4'd0, col}, 8'h0E);
    checkOutput("rst_buf", {4'd0, keypadBuf}, 8'h00);
    checkOutput("rst_valid", {7'd0, key_valid}, 8'd0);
    checkOutput("rst_held", {7'd0, key_held}, 8'd0);
    reset = 1'b0;

    for (int k = 1; k <= 16; k++) begin
      cycle();
      col_exp = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      checkOutput("idle_col_step", {4'd0, col}, {4'd0, col_exp});
    end

    start = pulse_count;
    sb.push_back(4'h5);
    pressed[1][1] = 1'b1;
    wait_pulse(start + 1, "key5");
    checkOutput("key5_buf", {4'd0, keypadBuf}, 8'h05);
    repeat (40) cycle();
    checkOutput("key5_held", {7'd0, key_held}, 8'd1);
    checkOutput("key5_col_frozen", {4'd0, col}, 8'h0D);
    pressed[1][1] = 1'b0;
    repeat (6) cycle();
    checkOutput("key5_held_early", {7'd0, key_held}, 8'd1);
    wait_release("key5");
    checkOutput("key5_resume_col", {4'd0, col}, 8'h0B);

    wait_col(4'b1011);
    pressed[2][2] = 1'b1;
    repeat (SCAN_DIV) cycle();
    pressed[2][2] = 1'b0;
    repeat (SCAN_DIV) cycle();
    checkOutput("bounce_resume_col", {4'd0, col}, 8'h07);
    checkOutput("bounce_buf", {4'd0, keypadBuf}, 8'h05);
    checkOutput("bounce_held", {7'd0, key_held}, 8'd0);
    applyStimulus(2, 2, 4'h9, "key9");

    applyStimulus(3, 0, 4'hE, "star");
    applyStimulus(3, 2, 4'hF, "hash");
    applyStimulus(3, 3, 4'hD, "keyD");
    applyStimulus(3, 1, 4'h0, "zero_a");
    applyStimulus(3, 1, 4'h0, "zero_b");

    start = pulse_count;
    sb.push_back(4'h1);
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
    wait_pulse(start + 1, "multi1");
    checkOutput("multi1_buf", {4'd0, keypadBuf}, 8'h01);
    pressed[0][1] = 1'b1;
    repeat (80) cycle();
    checkOutput("multi2_no_pulse", 8'(pulse_count - start), 8'd1);
    checkOutput("multi2_held", {7'd0, key_held}, 8'd1);
    checkOutput("multi2_col", {4'd0, col}, 8'h0E);
    sb.push_back(4'h2);
    pressed[0][0] = 1'b0;
    pressed[1][0] = 1'b0;
    wait_release("multi1");
    wait_pulse(start + 2, "multi2");
    checkOutput("multi2_buf", {4'd0, keypadBuf}, 8'h02);
    pressed[0][1] = 1'b0;
    wait_release("multi2");

    wait_col(4'b1101);
    pressed[1][1] = 1'b1;
    repeat (2 * SCAN_DIV) cycle();
    checkOutput("midrst_frozen", {4'd0, col}, 8'h0D);
    checkOutput("midrst_no_pulse", {7'd0, key_valid}, 8'd0);
    reset = 1'b1;
    cycle();
    checkOutput("midrst_col", {4'd0, col}, 8'h0E);
    checkOutput("midrst_buf", {4'd0, keypadBuf}, 8'h00);
    checkOutput("midrst_valid", {7'd0, key_valid}, 8'd0);
    checkOutput("midrst_held", {7'd0, key_held}, 8'd0);
    cycle();
    reset = 1'b0;
    start = pulse_count;
    sb.push_back(4'h5);
    wait_pulse(start + 1, "redetect");
    checkOutput("redetect_buf", {4'd0, keypadBuf}, 8'h05);
    pressed[1][1] = 1'b0;
    wait_release("redetect");
    repeat (4) cycle();

    checkOutput("sb_drain", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
    $finish;
  end

endmodule
